// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg : shared FSM encoding and helpers for UART control blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int unsigned TIMEOUT_CNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick : combinational round-robin picker, scan up from ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Walk offsets from farthest to nearest so the nearest valid slot wins.
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = (int'(ptr_i) + off) % NUM_REQ;
      if (valid_i[j]) begin
        idx_o = IDX_W'(j);
        any_o = 1'b1;
      end
    end
    grant_o[idx_o] = any_o;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one 8N1 transmitter, one byte/grant
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        tx_start_o,
  output logic [DATA_W-1:0]           tx_data_o,
  input  logic                        tx_busy_i,
  output logic [clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                        active_o,
  output logic                        err_timeout_o
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(START_TIMEOUT - 1);

  arb_state_e               state_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic [NUM_REQ-1:0]       req_ready_q;
  logic                     tx_start_q;
  logic [DATA_W-1:0]        tx_data_q;
  logic [IDX_W-1:0]         grant_id_q;
  logic                     active_q;
  logic                     err_timeout_q;

  logic [NUM_REQ-1:0]       pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;
  logic [DATA_W-1:0]        pick_data;
  logic [IDX_W-1:0]         ptr_d;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign pick_data = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];

  // Pointer moves past the last grant whether the frame completed or was dropped.
  assign ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      active_q      <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any && !tx_busy_i) begin
            req_ready_q <= pick_grant;
            tx_start_q  <= 1'b1;
            tx_data_q   <= pick_data;
            grant_id_q  <= pick_idx;
            active_q    <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_timeout_q <= 1'b1;
            active_q      <= 1'b0;
            ptr_q         <= ptr_d;
            state_q       <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            active_q <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_id_q;
  assign active_o      = active_q;
  assign err_timeout_o = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench with a transmitter model for uart_tx_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_timeout;

  logic foreign_busy = 1'b0;
  logic xmit_en = 1'b1;
  logic rand_len = 1'b0;
  logic rand_drop = 1'b0;
  logic refill = 1'b0;
  logic rnd_mode = 1'b0;
  int   xm_len = 10;
  int   xm_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   issued = 0;
  int   launches = 0;
  int   budget = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } ent_t;
  ent_t sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_W        (W),
    .START_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_busy_i     (tx_busy),
    .grant_id_o    (grant_id),
    .active_o      (active),
    .err_timeout_o (err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue_byte(input int i, input logic [W-1:0] b);
    ent_t e;
    e.idx  = i;
    e.data = b;
    req_data[i*W +: W] = b;
    req_valid[i] = 1'b1;
    sb.push_back(e);
    issued++;
  endtask

  task automatic issue(input int i);
    issue_byte(i, W'($urandom));
  endtask

  // One cycle of requester behaviour: retire accepted bytes, optionally offer new ones.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (refill) issue(i);
        else req_valid[i] = 1'b0;
      end
      if (rnd_mode && !req_valid[i] && issued < budget && $urandom_range(0, 3) == 0)
        issue(i);
    end
  endtask

  task automatic wait_start(input string name, input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < limit);
    if (!tx_start) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=no_tx_start expected=tx_start within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((active || req_valid != '0) && n < limit) begin
      tick();
      n++;
    end
    if (active || req_valid != '0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=still_busy expected=idle within %0d cycles", name, limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    sb.delete();
    foreign_busy = 1'b0;
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_active", active, 0);
    chk("rst_err_timeout", err_timeout, 0);
    tick();
    rst_n = 1'b1;
  endtask

  // Transmitter model: busy for a frame length starting in the launch cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        xm_cnt = 0;
      end else begin
        if (xm_cnt > 0) xm_cnt--;
        if (tx_start && xmit_en) begin
          if (!(rand_drop && $urandom_range(0, 7) == 0))
            xm_cnt = rand_len ? int'($urandom_range(3, 12)) : xm_len;
        end
      end
      tx_busy = foreign_busy | (xm_cnt > 0);
    end
  end

  // Monitor: predicts each grant from the requests visible at the sampling edge.
  initial begin
    logic [N-1:0] pv;
    logic [W-1:0] last_data;
    int mptr;
    int g;
    int j;
    int hit;
    pv = '0;
    last_data = '0;
    mptr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mptr = 0;
        pv = '0;
      end else begin
        if (tx_start) begin
          launches++;
          g = -1;
          for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && pv[j]) g = j;
          end
          if (g < 0) begin
            checks++;
            failures++;
            $display("FAIL launch_no_request: actual=grant %0d expected=no launch", grant_id);
          end else begin
            chk("mon_grant_id", grant_id, g);
            chk("mon_req_ready", req_ready, 1 << g);
            hit = -1;
            foreach (sb[k]) if (hit < 0 && sb[k].idx == g) hit = k;
            if (hit < 0) begin
              checks++;
              failures++;
              $display("FAIL mon_scoreboard: actual=launch for %0d expected=pending byte", g);
            end else begin
              chk("mon_tx_data", tx_data, sb[hit].data);
              sb.delete(hit);
            end
            mptr = (g + 1) % N;
          end
          last_data = tx_data;
        end else begin
          if (req_ready != '0) begin
            checks++;
            failures++;
            $display("FAIL ready_without_start: actual=%0h expected=0", req_ready);
          end
          if (active) chk("mon_tx_data_stable", tx_data, last_data);
        end
      end
      pv = req_valid;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    do_reset();

    // Single request: launch one cycle after sampling, frame tracked to the end.
    xm_len = 10;
    issue_byte(2, 8'hA5);
    tick();
    chk("t1_tx_start", tx_start, 1);
    chk("t1_req_ready", req_ready, 4'b0100);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_active", active, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_busy && n < 100);
    chk("t1_frame_cycles", n, 11);
    chk("t1_active_after", active, 0);

    // Pointer sits at 3: wrap to 0, then 1.
    issue(0);
    issue(1);
    wait_start("t3_first", 50);
    chk("t3_first_grant", grant_id, 0);
    wait_start("t3_second", 50);
    chk("t3_second_grant", grant_id, 1);
    wait_idle("t3_idle", 50);

    // Fairness with every requester continuously valid.
    do_reset();
    xm_len = 4;
    refill = 1'b1;
    for (int i = 0; i < N; i++) issue(i);
    for (int f = 0; f < 8; f++) begin
      wait_start("t2_start", 50);
      chk("t2_grant_order", grant_id, f % N);
    end
    refill = 1'b0;
    wait_idle("t2_idle", 200);

    // Transmitter never answers: timeout, drop, move on.
    xmit_en = 1'b0;
    issue(0);
    issue(1);
    wait_start("t4_start", 50);
    chk("t4_grant0", grant_id, 0);
    repeat (15) tick();
    chk("t4_err_before", err_timeout, 0);
    tick();
    chk("t4_err_after", err_timeout, 1);
    chk("t4_active_idle", active, 0);
    tick();
    chk("t4_next_start", tx_start, 1);
    chk("t4_next_grant", grant_id, 1);
    wait_idle("t4_idle", 50);
    xmit_en = 1'b1;

    // Foreign busy while idle holds off the grant.
    xm_len = 5;
    foreign_busy = 1'b1;
    tick();
    issue(3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold", tx_start, 0);
    end
    foreign_busy = 1'b0;
    tick();
    chk("t5_start", tx_start, 1);
    chk("t5_grant", grant_id, 3);
    wait_idle("t5_idle", 50);

    // Reset during the frame.
    xm_len = 10;
    issue(2);
    wait_start("t6_start", 50);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_active", active, 0);
    chk("t6_tx_start", tx_start, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_grant_id", grant_id, 0);
    chk("t6_err", err_timeout, 0);
    req_valid = '0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    issue(1);
    issue(3);
    wait_start("t6_after1", 50);
    chk("t6_after_grant1", grant_id, 1);
    wait_start("t6_after2", 50);
    chk("t6_after_grant2", grant_id, 3);
    wait_idle("t6_idle", 50);

    // Randomised traffic with variable frame lengths and occasional drops.
    do_reset();
    rand_len = 1'b1;
    rand_drop = 1'b1;
    budget = issued + 300;
    rnd_mode = 1'b1;
    n = 0;
    while (!(issued >= budget && req_valid == '0 && !active) && n < 30000) begin
      tick();
      n++;
    end
    rnd_mode = 1'b0;
    if (n >= 30000) begin
      checks++;
      failures++;
      $display("FAIL rnd_drain: actual=pending expected=drained");
    end
    tick();
    tick();
    chk("final_launch_count", launches, issued);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
